// File: rtl/ft245_arb_pkg.sv
// Shared definitions for the FT245 transmit arbiter: FSM state encoding,
// tag-header constants and the byte-counter width.
package ft245_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    TAG  = 3'd2,
    SEND = 3'd3,
    GAP  = 3'd4
  } arb_state_t;

  // High nibble of the optional per-burst header byte.
  localparam logic [3:0] TAG_PREFIX = 4'hA;

  // Cycles of forced WR# high time between bursts.
  localparam int GAP_CYCLES = 1;

  // Burst byte counter width; holds BURST_MAX up to 256.
  localparam int CNT_W = 9;

  // Header byte announcing which requester owns the following burst.
  function automatic logic [7:0] tag_byte(input logic [2:0] gid);
    return {TAG_PREFIX, 1'b0, gid};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester search. The search starts one past the stored
// pointer and wraps; the pointer is only moved when a burst finishes, so
// the requester that just finished becomes the lowest priority.
module rr_arbiter
  import ft245_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_adv,
  input  logic [ID_W-1:0]    i_adv_idx,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;
  logic            w_found;

  // Pointer remembers the last requester that completed a burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
    end else if (i_adv) begin
      r_ptr <= i_adv_idx;
    end
  end

  // First requesting lane after the pointer, with wrap-around.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end

endmodule

// File: rtl/ft245_tx_arbiter.sv
// FT245 transmit-port arbiter: shares one asynchronous-FIFO write port
// between NUM_REQ valid/ready/last byte streams, round-robin per burst.
// A burst ends on the owner's last byte or after BURST_MAX bytes, followed
// by a one-cycle WR# high gap.
// Optional build macro FT245_ARB_TAG_EN: each burst is preceded by a
// header byte {4'hA, 1'b0, grant_id}.
module ft245_tx_arbiter
  import ft245_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int BURST_MAX = 64,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 txe_n,
  output logic                 wr_n,
  output logic [7:0]           data_out,
  input  logic [8*NUM_REQ-1:0] in_data,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [NUM_REQ-1:0]   in_last,
  output logic [NUM_REQ-1:0]   in_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [ID_W-1:0]    r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_gap;

  logic [NUM_REQ-1:0] w_arb_gnt;
  logic [ID_W-1:0]    w_arb_idx;
  logic [7:0]         w_lanes [NUM_REQ];
  logic               w_any_valid;
  logic               w_beat;
  logic               w_burst_end;
  logic               w_gap_done;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_wr_n;
  logic [NUM_REQ-1:0] w_ready;
  logic [7:0]         w_data;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign w_lanes[gi] = in_data[8*gi +: 8];
  end

  assign w_any_valid = |in_valid;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_gap_done  = (r_gap == 4'(GAP_CYCLES - 1));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .i_clk     (clock_in),
    .i_rst_n   (reset_n),
    .i_req     (in_valid),
    .i_adv     (w_burst_end),
    .i_adv_idx (r_grant),
    .o_gnt     (w_arb_gnt),
    .o_idx     (w_arb_idx)
  );

  // State register.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and the combinational FT245 strobe / handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_n      = 1'b1;
    w_ready     = '0;
    w_data      = '0;
    w_beat      = 1'b0;
    w_burst_end = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable && !txe_n && w_any_valid) begin
          w_state_nxt = ARB;
        end
      end
      ARB: begin
        if (|w_arb_gnt) begin
`ifdef FT245_ARB_TAG_EN
          w_state_nxt = TAG;
`else
          w_state_nxt = SEND;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
`ifdef FT245_ARB_TAG_EN
      TAG: begin
        w_wr_n = txe_n;
        w_data = tag_byte(3'(r_grant));
        if (!txe_n) begin
          w_state_nxt = SEND;
        end
      end
`endif
      SEND: begin
        // Stalls only hold the burst; enable is deliberately ignored here.
        w_data           = w_lanes[r_grant];
        w_beat           = in_valid[r_grant] & ~txe_n;
        w_wr_n           = ~w_beat;
        w_ready[r_grant] = w_beat;
        if (w_beat && (in_last[r_grant] || (w_cnt_inc == CNT_W'(BURST_MAX)))) begin
          w_burst_end = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (w_gap_done) begin
          w_state_nxt = (enable && w_any_valid && !txe_n) ? ARB : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Granted lane, burst byte counter and gap timer.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_grant <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
    end else begin
      if (r_state == ARB && |w_arb_gnt) begin
        r_grant <= w_arb_idx;
      end
      if (r_state == ARB) begin
        r_cnt <= '0;
      end else if (w_beat && (r_cnt != CNT_W'(BURST_MAX))) begin
        r_cnt <= w_cnt_inc;
      end
      if (r_state == GAP) begin
        r_gap <= r_gap + 4'd1;
      end else begin
        r_gap <= '0;
      end
    end
  end

  assign wr_n     = w_wr_n;
  assign in_ready = w_ready;
  assign data_out = w_data;
  assign grant_id = r_grant;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// Self-checking bench for ft245_tx_arbiter: per-cycle comparison against a
// behavioural model plus literal expectations for directed scenarios,
// then a randomized traffic phase.
module tb_ft245_tx_arbiter;

  localparam int NR = 4;
  localparam int BM = 4;
`ifdef FT245_ARB_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif
  localparam int HOP = TAG_ON ? 4 : 3;
  localparam int M_IDLE = 0, M_ARB = 1, M_TAG = 2, M_SEND = 3, M_GAP = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          txe_n;
  logic          wr_n;
  logic [7:0]    data_out;
  logic [8*NR-1:0] in_data;
  logic [NR-1:0] in_valid;
  logic [NR-1:0] in_last;
  logic [NR-1:0] in_ready;
  logic [1:0]    grant_id;
  logic          busy;

  ft245_tx_arbiter #(.NUM_REQ(NR), .BURST_MAX(BM)) dut (
    .clock_in (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .txe_n    (txe_n),
    .wr_n     (wr_n),
    .data_out (data_out),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .grant_id (grant_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Requester sources: {last, byte} per queued entry.
  logic [8:0] srcq [NR][$];
  // Logs of payload beats (byte, owner, cycle) and of every byte written.
  logic [7:0] plog_d [$];
  int         plog_g [$];
  int         plog_c [$];
  logic [7:0] flog   [$];

  int   m_mode, m_ptr, m_gid, m_cnt;
  bit   rand_mode = 1'b0;
  logic tb_txe = 1'b0;
  int   cyc = 0;
  logic s_wr_n, s_busy;
  logic [NR-1:0] s_rdy;
  logic [1:0] s_gid;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      int idx;
      idx = (ptr + k) % NR;
      if (((v >> idx) & 1) != 0) return idx;
    end
    return -1;
  endfunction

  function automatic logic bit_of(input logic [NR-1:0] v, input int i);
    return 1'((v >> i) & 1);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_ptr  = NR - 1;
    m_gid  = 0;
    m_cnt  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    txe_n    = 1'b1;
    enable   = 1'b0;
    tb_txe   = 1'b0;
    for (int i = 0; i < NR; i++) srcq[i].delete();
    plog_d.delete(); plog_g.delete(); plog_c.delete(); flog.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
  endtask

  // One clock: drive at negedge, compare against the model, advance model.
  task automatic cycle();
    logic [NR-1:0] v, l, e_rdy, pop;
    logic [8*NR-1:0] d;
    logic e_wr_n;
    logic [7:0] e_data;
    int p;
    @(negedge clk);
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NR; i++) begin
      logic [7:0] b;
      logic lb;
      if (srcq[i].size() > 0) begin
        b  = srcq[i][0][7:0];
        lb = srcq[i][0][8];
        if (!rand_mode || $urandom_range(0, 3) != 0) v = v | (NR'(1) << i);
      end else begin
        b  = 8'($urandom);
        lb = 1'($urandom);
      end
      d = d | ((8*NR)'(b) << (8*i));
      l = l | (NR'(lb) << i);
    end
    in_valid = v; in_last = l; in_data = d;
    if (rand_mode) begin
      txe_n  = ($urandom_range(0, 5) == 0);
      enable = ($urandom_range(0, 15) != 0);
    end else begin
      txe_n  = tb_txe;
      enable = 1'b1;
    end
    #1;
    e_wr_n = 1'b1; e_rdy = '0; e_data = '0;
    if (m_mode == M_TAG) begin
      e_wr_n = txe_n;
      e_data = {4'hA, 1'b0, 3'(m_gid)};
    end else if (m_mode == M_SEND && bit_of(in_valid, m_gid) && !txe_n) begin
      e_wr_n = 1'b0;
      e_rdy  = NR'(1) << m_gid;
      e_data = 8'(in_data >> (8*m_gid));
    end
    chk("wr_n", 32'(wr_n), 32'(e_wr_n));
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    if (e_wr_n == 1'b0) chk("data_out", 32'(data_out), 32'(e_data));
    s_wr_n = wr_n; s_rdy = in_ready; s_gid = grant_id; s_busy = busy;
    if (wr_n == 1'b0) begin
      flog.push_back(data_out);
      if (in_ready != '0) begin
        plog_d.push_back(data_out);
        plog_g.push_back(int'(grant_id));
        plog_c.push_back(cyc);
      end
    end
    pop = in_valid & in_ready;
    case (m_mode)
      M_IDLE: if (enable && !txe_n && in_valid != '0) m_mode = M_ARB;
      M_ARB: begin
        p = rr_pick(m_ptr, in_valid);
        if (p < 0) m_mode = M_IDLE;
        else begin
          m_gid  = p;
          m_cnt  = 0;
          m_mode = TAG_ON ? M_TAG : M_SEND;
        end
      end
      M_TAG:  if (!txe_n) m_mode = M_SEND;
      M_SEND: if (e_wr_n == 1'b0) begin
        m_cnt++;
        if (bit_of(in_last, m_gid) || m_cnt == BM) begin
          m_ptr  = m_gid;
          m_mode = M_GAP;
        end
      end
      default: m_mode = (enable && in_valid != '0 && !txe_n) ? M_ARB : M_IDLE;
    endcase
    @(posedge clk);
    for (int i = 0; i < NR; i++) if (bit_of(pop, i)) void'(srcq[i].pop_front());
    cyc++;
  endtask

  task automatic run_until(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (plog_d.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk({nm, "_beats"}, 32'(plog_d.size()), 32'(n));
  endtask

  task automatic push_pkt(input int r, input logic [7:0] first, input int len, input bit with_last);
    for (int k = 0; k < len; k++)
      srcq[r].push_back({(with_last && k == len - 1), 8'(first + 8'(k))});
  endtask

  initial begin
    int exp_g [$];
    logic [7:0] exp_d [$];

    // 1: reset state, then asynchronous reset during the 3rd byte.
    do_reset();
    #1;
    chk("rst_wr_n", 32'(wr_n), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    push_pkt(0, 8'hC1, 5, 1'b1);
    run_until(2, 20, "t1");
    @(negedge clk);
    in_data  = (8*NR)'(srcq[0][0][7:0]);
    in_valid = 4'b0001;
    in_last  = '0;
    txe_n    = 1'b0;
    #1;
    chk("t1_third_byte_wr_n", 32'(wr_n), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t1_async_wr_n", 32'(wr_n), 32'd1);
    chk("t1_async_in_ready", 32'(in_ready), 32'd0);
    chk("t1_async_busy", 32'(busy), 32'd0);
    do_reset();
    cycle();
    chk("t1_idle_after_release", 32'(s_busy), 32'd0);

    // 2: requesters 0 and 2, three-byte packets.
    do_reset();
    push_pkt(0, 8'h01, 3, 1'b1);
    push_pkt(2, 8'h21, 3, 1'b1);
    run_until(6, 60, "t2");
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h21, 8'h22, 8'h23};
    exp_g = '{0, 0, 0, 2, 2, 2};
    for (int i = 0; i < 6 && i < plog_d.size(); i++) begin
      chk($sformatf("t2_byte%0d", i), 32'(plog_d[i]), 32'(exp_d[i]));
      chk($sformatf("t2_owner%0d", i), 32'(plog_g[i]), 32'(exp_g[i]));
    end
    if (plog_c.size() >= 4) chk("t2_gap_spacing", 32'(plog_c[3] - plog_c[2]), 32'(HOP));

    // 3: all four requesters, two-byte packets.
    do_reset();
    for (int r = 0; r < NR; r++) begin
      push_pkt(r, 8'(16*r), 2, 1'b1);
      push_pkt(r, 8'(16*r + 8), 2, 1'b1);
    end
    run_until(16, 200, "t3");
    exp_g = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
    for (int i = 0; i < 16 && i < plog_g.size(); i++)
      chk($sformatf("t3_owner%0d", i), 32'(plog_g[i]), 32'(exp_g[i]));

    // 4: BURST_MAX splits an unterminated stream around requester 3.
    do_reset();
    push_pkt(1, 8'h10, 10, 1'b0);
    push_pkt(3, 8'h30, 1, 1'b1);
    push_pkt(3, 8'h31, 1, 1'b1);
    run_until(12, 100, "t4");
    exp_g = '{1, 1, 1, 1, 3, 1, 1, 1, 1, 3, 1, 1};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h14, 8'h15, 8'h16, 8'h17, 8'h31, 8'h18, 8'h19};
    for (int i = 0; i < 12 && i < plog_g.size(); i++) begin
      chk($sformatf("t4_owner%0d", i), 32'(plog_g[i]), 32'(exp_g[i]));
      chk($sformatf("t4_byte%0d", i), 32'(plog_d[i]), 32'(exp_d[i]));
    end

    // 5: FIFO full for 5 cycles mid-burst.
    do_reset();
    push_pkt(0, 8'h51, 6, 1'b1);
    run_until(2, 20, "t5a");
    tb_txe = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk($sformatf("t5_stall%0d_wr_n", k), 32'(s_wr_n), 32'd1);
      chk($sformatf("t5_stall%0d_ready", k), 32'(s_rdy), 32'd0);
      chk($sformatf("t5_stall%0d_gid", k), 32'(s_gid), 32'd0);
    end
    tb_txe = 1'b0;
    run_until(6, 40, "t5b");
    for (int i = 0; i < 6 && i < plog_d.size(); i++)
      chk($sformatf("t5_byte%0d", i), 32'(plog_d[i]), 32'(8'h51 + 8'(i)));
    if (plog_c.size() >= 6) begin
      chk("t5_resume", 32'(plog_c[2] - plog_c[1]), 32'd6);
      chk("t5_cnt_continues", 32'(plog_c[3] - plog_c[2]), 32'd1);
      chk("t5_burst_split", 32'(plog_c[4] - plog_c[3]), 32'(HOP));
    end

`ifdef FT245_ARB_TAG_EN
    // 6: header byte ahead of the payload.
    do_reset();
    srcq[2].push_back({1'b0, 8'h11});
    srcq[2].push_back({1'b1, 8'h22});
    run_until(2, 20, "t6");
    exp_d = '{8'hA2, 8'h11, 8'h22};
    chk("t6_len", 32'(flog.size()), 32'd3);
    for (int i = 0; i < 3 && i < flog.size(); i++)
      chk($sformatf("t6_byte%0d", i), 32'(flog[i]), 32'(exp_d[i]));
`endif

    // Randomized traffic, FIFO-full and enable toggling.
    do_reset();
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (srcq[r].size() == 0 && $urandom_range(0, 2) == 0)
          push_pkt(r, 8'($urandom), $urandom_range(1, 7), 1'b1);
      end
      cycle();
    end
    rand_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
